// File: rtl/gpio_bank.sv
// GPIO bank: WIDTH pins with output/direction registers, synchronised inputs,
// sticky rising/falling edge events and a level interrupt.

module gpio_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pad,
  output logic in_q,
  output logic prev_q
);
  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain  <= '0;
      prev_q <= 1'b0;
    end else begin
      chain  <= {chain[SYNC_STAGES-2:0], pad};
      prev_q <= chain[SYNC_STAGES-1];
    end
  end

  assign in_q = chain[SYNC_STAGES-1];
endmodule

module gpio_bank #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_wr,
  input  logic             io_rd,
  input  logic [2:0]       io_addr,
  input  logic [15:0]      dout,
  output logic [15:0]      io_din,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic             irq
);
  localparam logic [2:0] A_DATA = 3'd0, A_DIR = 3'd1, A_SET = 3'd2, A_CLR = 3'd3,
                         A_TGL = 3'd4, A_RISE = 3'd5, A_FALL = 3'd6, A_EVENT = 3'd7;

  logic [WIDTH-1:0] out_q, dir_q, rise_en_q, fall_en_q, event_q;
  logic [WIDTH-1:0] in_s, prev_s, wdata, ev_clr, ev_new, rd_sel;
  logic [15:0]      rd_ext;

  assign wdata = dout[WIDTH-1:0];

  generate
    if (WIDTH < 16) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^dout[15:WIDTH];
    end
  endgenerate

  gpio_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync [WIDTH-1:0] (
    .clk    (clk),
    .reset  (reset),
    .pad    (pin_in),
    .in_q   (in_s),
    .prev_q (prev_s)
  );

  // Edges are taken from the pad itself, so driven pins also see their own value.
  assign ev_new = (in_s & ~prev_s & rise_en_q) | (~in_s & prev_s & fall_en_q);
  assign ev_clr = (io_wr && io_addr == A_EVENT) ? wdata : '0;

  always_comb begin
    rd_sel = '0;
    case (io_addr)
      A_DATA:               rd_sel = in_s;
      A_DIR:                rd_sel = dir_q;
      A_SET, A_CLR, A_TGL:  rd_sel = out_q;
      A_RISE:               rd_sel = rise_en_q;
      A_FALL:               rd_sel = fall_en_q;
      default:              rd_sel = event_q;
    endcase
    rd_ext            = '0;
    rd_ext[WIDTH-1:0] = rd_sel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      event_q   <= '0;
      io_din    <= '0;
      irq       <= 1'b0;
    end else begin
      // New event is OR'd after the clear so it wins a same-cycle race.
      event_q <= (event_q & ~ev_clr) | ev_new;
      irq     <= |event_q;
      if (io_rd) io_din <= rd_ext;
      if (io_wr) begin
        case (io_addr)
          A_DATA:  out_q     <= wdata;
          A_DIR:   dir_q     <= wdata;
          A_SET:   out_q     <= out_q | wdata;
          A_CLR:   out_q     <= out_q & ~wdata;
          A_TGL:   out_q     <= out_q ^ wdata;
          A_RISE:  rise_en_q <= wdata;
          A_FALL:  fall_en_q <= wdata;
          default: ;
        endcase
      end
    end
  end

  assign pin_out = out_q;
  assign pin_oe  = dir_q;
endmodule

// File: tb/tb_gpio_bank.sv
// Bench for gpio_bank: WIDTH=8/SYNC=2 and WIDTH=5/SYNC=3 instances driven in
// lockstep, checked every cycle against a register-map level model.

module tb_gpio_bank;
  logic        clk = 1'b0;
  logic        reset;
  logic        io_wr, io_rd;
  logic [2:0]  io_addr;
  logic [15:0] dout;
  logic [7:0]  pin;
  logic [15:0] din0, din1;
  logic [7:0]  po0, oe0;
  logic [4:0]  po1, oe1;
  logic        irq0, irq1;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  gpio_bank #(.WIDTH(8), .SYNC_STAGES(2)) u_dut0 (
    .clk(clk), .reset(reset), .io_wr(io_wr), .io_rd(io_rd), .io_addr(io_addr),
    .dout(dout), .io_din(din0), .pin_in(pin), .pin_out(po0), .pin_oe(oe0), .irq(irq0)
  );

  gpio_bank #(.WIDTH(5), .SYNC_STAGES(3)) u_dut1 (
    .clk(clk), .reset(reset), .io_wr(io_wr), .io_rd(io_rd), .io_addr(io_addr),
    .dout(dout), .io_din(din1), .pin_in(pin[4:0]), .pin_out(po1), .pin_oe(oe1), .irq(irq1)
  );

  // Reference model, one set of registers per instance.
  logic [15:0] m_out[2], m_dir[2], m_rise[2], m_fall[2], m_ev[2], m_din[2];
  logic        m_irq[2];
  logic [15:0] smp[2][5]; // smp[d][k] = pad value sampled k edges ago

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_out[d] = 0; m_dir[d] = 0; m_rise[d] = 0; m_fall[d] = 0;
      m_ev[d] = 0; m_din[d] = 0; m_irq[d] = 1'b0;
      for (int k = 0; k < 5; k++) smp[d][k] = 0;
    end
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      logic [15:0] msk, inv, prv, sel, wd, nev;
      int ss;
      msk = (d == 0) ? 16'h00FF : 16'h001F;
      ss  = (d == 0) ? 2 : 3;
      inv = smp[d][ss-1];
      prv = smp[d][ss];
      wd  = dout & msk;
      case (io_addr)
        3'd0:             sel = inv;
        3'd1:             sel = m_dir[d];
        3'd2, 3'd3, 3'd4: sel = m_out[d];
        3'd5:             sel = m_rise[d];
        3'd6:             sel = m_fall[d];
        default:          sel = m_ev[d];
      endcase
      if (io_rd) m_din[d] = sel;
      m_irq[d] = |m_ev[d];
      nev = m_ev[d] & ~((io_wr && io_addr == 3'd7) ? wd : 16'h0);
      nev = nev | (inv & ~prv & m_rise[d]) | (~inv & prv & m_fall[d]);
      m_ev[d] = nev & msk;
      if (io_wr) begin
        case (io_addr)
          3'd0: m_out[d]  = wd;
          3'd1: m_dir[d]  = wd;
          3'd2: m_out[d]  = m_out[d] | wd;
          3'd3: m_out[d]  = m_out[d] & ~wd;
          3'd4: m_out[d]  = m_out[d] ^ wd;
          3'd5: m_rise[d] = wd;
          3'd6: m_fall[d] = wd;
          default: ;
        endcase
      end
      for (int k = 4; k > 0; k--) smp[d][k] = smp[d][k-1];
      smp[d][0] = {8'h00, pin} & msk;
    end
  endtask

  task automatic compare_all();
    chk("pin_out0", {8'h00, po0}, m_out[0]);
    chk("pin_oe0",  {8'h00, oe0}, m_dir[0]);
    chk("irq0",     {15'h0, irq0}, {15'h0, m_irq[0]});
    chk("io_din0",  din0, m_din[0]);
    chk("pin_out1", {11'h0, po1}, m_out[1]);
    chk("pin_oe1",  {11'h0, oe1}, m_dir[1]);
    chk("irq1",     {15'h0, irq1}, {15'h0, m_irq[1]});
    chk("io_din1",  din1, m_din[1]);
  endtask

  // One bus cycle: drive, clock, advance the model, compare 1 time unit later.
  task automatic cyc(input logic wr, input logic rd, input logic [2:0] a,
                     input logic [15:0] dat, input logic [7:0] p);
    io_wr = wr; io_rd = rd; io_addr = a; dout = dat; pin = p;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] dat);
    cyc(1'b1, 1'b0, a, dat, pin);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    cyc(1'b0, 1'b1, a, 16'h0, pin);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, 16'h0, pin);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; io_wr = 1'b0; io_rd = 1'b0; io_addr = 3'd0; dout = 16'h0; pin = 8'h00;
    model_reset();
    cyc(1'b1, 1'b1, 3'd1, 16'hFFFF, 8'hFF); // access during reset is discarded
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 8'h00);
    reset = 1'b0;
    idle(3);

    // Output set/clear/toggle and loopback read.
    wr_reg(3'd1, 16'h00FF);
    wr_reg(3'd0, 16'h000F);
    wr_reg(3'd2, 16'h0030);
    wr_reg(3'd3, 16'h0003);
    wr_reg(3'd4, 16'h0081);
    chk("sct_pin_out", {8'h00, po0}, 16'h00BD);
    chk("sct_pin_oe",  {8'h00, oe0}, 16'h00FF);
    pin = po0;
    idle(4);
    rd_reg(3'd0);
    chk("loopback_din", din0, 16'h00BD);
    pin = 8'h00;
    idle(5);

    // Rising-edge event latency and stickiness.
    wr_reg(3'd5, 16'h0001);
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 8'h01);
    idle(2);
    chk("irq_before", {15'h0, irq0}, 16'h0000);
    idle(1);
    chk("irq_after", {15'h0, irq0}, 16'h0001);
    for (int i = 0; i < 4; i++) begin
      pin = 8'h00; idle(3);
      pin = 8'h01; idle(3);
    end
    pin = 8'h00; idle(4);
    rd_reg(3'd7);
    chk("rise_event", din0, 16'h0001);

    // Clear racing a new fall event on bit 2.
    wr_reg(3'd6, 16'h0004);
    pin = 8'h04; idle(4);
    pin = 8'h00; idle(5);                  // first fall event sets EVENT[2]
    pin = 8'h04; idle(4);
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 8'h00);   // drop bit 2
    idle(1);
    wr_reg(3'd7, 16'h0004);                // clear coincides with event (SYNC=2)
    rd_reg(3'd7);
    chk("race_event", din0, 16'h0005);
    idle(3);
    wr_reg(3'd7, 16'h0004);
    wr_reg(3'd7, 16'h0001);
    idle(2);
    chk("irq_dropped", {15'h0, irq0}, 16'h0000);
    rd_reg(3'd7);
    chk("event_cleared", din0, 16'h0000);

    // Width masking and zero extension.
    wr_reg(3'd0, 16'hFFFF);
    chk("narrow_pin_out", {11'h0, po1}, 16'h001F);
    rd_reg(3'd0);
    chk("narrow_data", din1, 16'h0000);
    rd_reg(3'd1);
    chk("narrow_dir", din1, 16'h001F);

    // Asynchronous reset between edges with events pending.
    wr_reg(3'd5, 16'h00FF);
    pin = 8'hFF; idle(5);
    chk("pre_reset_irq", {15'h0, irq0}, 16'h0001);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("async_oe", {8'h00, oe0}, 16'h0000);
    chk("async_irq", {15'h0, irq0}, 16'h0000);
    cyc(1'b1, 1'b0, 3'd1, 16'h00FF, 8'hFF);
    cyc(1'b1, 1'b0, 3'd5, 16'h00FF, 8'hFF);
    reset = 1'b0;
    idle(6);
    chk("post_reset_irq", {15'h0, irq0}, 16'h0000);
    chk("post_reset_oe", {8'h00, oe0}, 16'h0000);
    rd_reg(3'd7);
    chk("post_reset_event", din0, 16'h0000);

    // Read timing and hold.
    wr_reg(3'd1, 16'h005A);
    rd_reg(3'd1);
    chk("rd_t1", din0, 16'h005A);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("rd_hold", din0, 16'h005A);
    end

    // Randomised traffic including simultaneous read and write.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] p;
      p = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pin;
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
          3'($urandom_range(0, 7)), 16'($urandom), p);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gpio_bank.md
GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of GPIO pins; legal range 1..16.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving input synchroniser depth; legal range 2..4.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port io_wr, input, 1 bit: register write strobe, one cycle per access.
REQ-006 The block SHALL have port io_rd, input, 1 bit: register read strobe, one cycle per access.
REQ-007 The block SHALL have port io_addr, input, 3 bits: register select.
REQ-008 The block SHALL have port dout, input, 16 bits: write data.
REQ-009 The block SHALL have port io_din, output, 16 bits: registered read data.
REQ-010 The block SHALL have port pin_in, input, WIDTH bits: raw pad inputs, asynchronous to clk.
REQ-011 The block SHALL have port pin_out, output, WIDTH bits: pad output values.
REQ-012 The block SHALL have port pin_oe, output, WIDTH bits: pad output enables (1 = drive).
REQ-013 The block SHALL have port irq, output, 1 bit: level interrupt request.

Function
REQ-014 The register map SHALL be: 0 DATA (r: synchronised input; w: OUT), 1 DIR, 2 SET, 3 CLR, 4 TGL, 5 RISE_EN, 6 FALL_EN, 7 EVENT.
REQ-015 A write to DATA SHALL load OUT <= dout[WIDTH-1:0] on the strobe edge.
REQ-016 Writes to SET, CLR and TGL SHALL respectively do OUT |= d, OUT &= ~d, and OUT ^= d; bits with d=0 are unchanged.
REQ-017 A DIR bit of 1 SHALL make the pin an output.
REQ-018 pin_out SHALL equal OUT.
REQ-019 pin_oe SHALL equal DIR.
REQ-020 Both pin_out and pin_oe SHALL come directly from registers, with no combinational path from any input.
REQ-021 Each pin_in bit SHALL pass through SYNC_STAGES flops; the last stage is IN.
REQ-022 A flop PREV SHALL hold IN delayed by one cycle.
REQ-023 A rising event for bit i SHALL be IN[i] & ~PREV[i] & RISE_EN[i].
REQ-024 A falling event for bit i SHALL be ~IN[i] & PREV[i] & FALL_EN[i].
REQ-025 Edge detection SHALL work regardless of DIR, so output pins see their own pad value.
REQ-026 EVENT bits SHALL be sticky.
REQ-027 Writing EVENT with a 1 in bit i SHALL clear bit i; writing 0 SHALL have no effect.
REQ-028 If a new event and a clear of the same bit occur in the same cycle, the event SHALL win and the bit ends at 1.
REQ-029 irq SHALL be a flop equal to |EVENT, registered one cycle after EVENT.
REQ-030 Reads SHALL complete the cycle after the io_rd cycle: io_din <= selected register, zero-extended to 16 bits.
REQ-031 io_din SHALL hold its value until the next io_rd.
REQ-032 Reads of SET, CLR and TGL SHALL return OUT.
REQ-033 Reads of RISE_EN, FALL_EN and EVENT SHALL return their register contents.
REQ-034 Reading any register SHALL have no side effects.
REQ-035 dout bits at and above WIDTH SHALL be ignored on writes; the same bits SHALL read as 0.
REQ-036 If io_wr and io_rd are asserted together, the write SHALL take effect and the read SHALL return the pre-write value.
REQ-037 Latencies: pin_in to IN is SYNC_STAGES cycles; IN edge to EVENT set is +1 cycle; EVENT to irq is +1 cycle; a write to pin_out/pin_oe is 1 cycle.

Reset
REQ-038 While reset is high, OUT, DIR, RISE_EN, FALL_EN, EVENT, the synchroniser flops, PREV, io_din and irq SHALL all be 0.
REQ-039 Consequently pin_oe = 0 (all pins inputs), pin_out = 0, io_din = 0 and irq = 0 during reset.
REQ-040 A reset asserted mid-operation SHALL return every register to its reset value immediately, without waiting for clk.
REQ-041 Any access whose strobe coincides with reset SHALL be discarded.
REQ-042 No event SHALL be raised after reset release, even with pins high, because all edge enables are 0 until software sets them.

Verification
REQ-043 Scenario, output set/clear/toggle (WIDTH=8): write DIR=0xFF, DATA=0x0F, SET=0x30, CLR=0x03, TGL=0x81 -> pin_out=0xBD; pin_oe=0xFF; read DATA with pin_in looped back -> io_din=0x00BD.
REQ-044 Scenario, rising edge: RISE_EN=0x01; pin_in[0] 0->1 at cycle t -> EVENT[0]=1 at t+SYNC_STAGES+1 and irq=1 one cycle later; further toggling with FALL_EN=0 keeps EVENT=0x01.
REQ-045 Scenario, clear race: EVENT[2] set; write EVENT=0x04 in the same cycle as a new fall event on bit 2 -> EVENT[2] stays 1; a later write of 0x04 with no event -> EVENT=0 and irq drops one cycle later.
REQ-046 Scenario, width/zero-extension: WIDTH=5; write DATA=0xFFFF -> pin_out=0x1F; read DATA and DIR -> io_din upper 11 bits are 0.
REQ-047 Scenario, async reset: assert reset between clock edges while DIR=0xFF and EVENT nonzero -> pin_oe=0, EVENT=0 and irq=0 before the next edge; with pin_in=0xFF held through reset release -> no event and irq stays 0.
REQ-048 Scenario, read timing: io_rd at cycle t with io_addr=1 -> io_din=DIR at t+1 and unchanged through t+5 with no further reads.
